// File: rtl/debug_pkg.sv
// Shared definitions for the pipeline run/step/dump controller.
//   - command codes presented on the debug command port
//   - controller state encoding (top FSM and dump sequencer)
//   - HALT opcode, as recognised upstream to produce i_halt_wb
//   - default command width
package debug_pkg;

    localparam int NB_CMD = 2;

    localparam logic [5:0] HALT_OPCODE = 6'b111111;

    typedef enum logic [1:0] {
        CMD_NOP  = 2'b00,
        CMD_RUN  = 2'b01,
        CMD_STEP = 2'b10,
        CMD_DUMP = 2'b11
    } cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_STEP    = 3'd2,
        ST_DUMP_RD = 3'd3,
        ST_DUMP_TX = 3'd4,
        ST_HALTED  = 3'd5
    } state_t;

endpackage

// File: rtl/pipeline_debug_ctrl_if.sv
// Signal bundle between the debug controller, the debug unit (command and
// dump word stream) and the pipeline (enable, halt detect, regfile port).
//   master : the controller side (pipeline_debug_ctrl)
//   slave  : the environment side (debug unit + pipeline)
// Optional DEBUG_PC_DUMP_EN adds i_pc, the current PC fed to the dump.
interface pipeline_debug_ctrl_if #(
    parameter int LEN     = 32,
    parameter int NB_ADDR = 5,
    parameter int NB_CMD  = 2
);

    logic               i_cmd_valid;
    logic [NB_CMD-1:0]  i_cmd;
    logic               o_cmd_ready;
    logic               i_halt_wb;
    logic               o_pipe_en;
    logic [NB_ADDR-1:0] o_dump_addr;
    logic [LEN-1:0]     i_dump_data;
    logic               o_tx_valid;
    logic [LEN-1:0]     o_tx_data;
    logic               i_tx_ready;
    logic               o_halted;
    logic [LEN-1:0]     o_cycle_count;
`ifdef DEBUG_PC_DUMP_EN
    logic [LEN-1:0]     i_pc;
`endif

    modport master (
        input  i_cmd_valid, i_cmd, i_halt_wb, i_dump_data, i_tx_ready,
`ifdef DEBUG_PC_DUMP_EN
               i_pc,
`endif
        output o_cmd_ready, o_pipe_en, o_dump_addr, o_tx_valid, o_tx_data,
               o_halted, o_cycle_count
    );

    modport slave (
        output i_cmd_valid, i_cmd, i_halt_wb, i_dump_data, i_tx_ready,
`ifdef DEBUG_PC_DUMP_EN
               i_pc,
`endif
        input  o_cmd_ready, o_pipe_en, o_dump_addr, o_tx_valid, o_tx_data,
               o_halted, o_cycle_count
    );

endinterface

// File: rtl/debug_dump_seq.sv
// Register-file dump sequencer.
// Started by a one-cycle i_start from the top FSM, it alternates between
// reading one register (DUMP_RD) and offering it on the word stream
// (DUMP_TX) until every register, [the PC], and the cycle count have been
// handed over, then pulses o_done combinationally on the final handshake.
// Ports:
//   i_clk, i_rst        clock, async active-high reset
//   i_start             begin a dump (only sampled while idle)
//   i_cycle_count       value sent as the final word
//   i_pc                PC captured at start (DEBUG_PC_DUMP_EN only)
//   o_dump_addr         regfile read address; i_dump_data is sampled at
//   i_dump_data         the end of the DUMP_RD cycle
//   o_tx_valid/o_tx_data/i_tx_ready   word stream
//   o_done              last word accepted this cycle
module debug_dump_seq
    import debug_pkg::*;
#(
    parameter int LEN     = 32,
    parameter int NB_ADDR = 5,
    parameter int NB_REGS = 32
)(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [LEN-1:0]     i_cycle_count,
`ifdef DEBUG_PC_DUMP_EN
    input  logic [LEN-1:0]     i_pc,
`endif
    output logic [NB_ADDR-1:0] o_dump_addr,
    input  logic [LEN-1:0]     i_dump_data,
    output logic               o_tx_valid,
    output logic [LEN-1:0]     o_tx_data,
    input  logic               i_tx_ready,
    output logic               o_done
);

`ifdef DEBUG_PC_DUMP_EN
    localparam int NB_WORDS = NB_REGS + 2;
`else
    localparam int NB_WORDS = NB_REGS + 1;
`endif
    localparam int NB_IDX = $clog2(NB_WORDS);
    localparam logic [NB_IDX-1:0] LAST_IDX  = NB_IDX'(NB_WORDS - 1);
    localparam logic [NB_IDX-1:0] NREGS_IDX = NB_IDX'(NB_REGS);

    state_t             state_q, state_d;
    logic [NB_IDX-1:0]  widx_q, widx_d, widx_inc;
    logic [NB_ADDR-1:0] addr_q, addr_d;
    logic               valid_q, valid_d;
    logic [LEN-1:0]     data_q, data_d, word;
`ifdef DEBUG_PC_DUMP_EN
    logic [LEN-1:0]     pc_q, pc_d;
`endif

    assign widx_inc = widx_q + 1'b1;

    // Word index past the register range selects the trailing words.
    always_comb begin
        word = i_cycle_count;
        if (widx_q < NREGS_IDX) begin
            word = i_dump_data;
        end
`ifdef DEBUG_PC_DUMP_EN
        else if (widx_q == NREGS_IDX) begin
            word = pc_q;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        widx_d  = widx_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        data_d  = data_q;
`ifdef DEBUG_PC_DUMP_EN
        pc_d    = pc_q;
`endif
        o_done  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_DUMP_RD;
                    widx_d  = '0;
                    addr_d  = '0;
`ifdef DEBUG_PC_DUMP_EN
                    pc_d    = i_pc;
`endif
                end
            end
            ST_DUMP_RD: begin
                state_d = ST_DUMP_TX;
                valid_d = 1'b1;
                data_d  = word;
            end
            ST_DUMP_TX: begin
                if (i_tx_ready) begin
                    valid_d = 1'b0;
                    if (widx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                        widx_d  = '0;
                        addr_d  = '0;
                        o_done  = 1'b1;
                    end else begin
                        state_d = ST_DUMP_RD;
                        widx_d  = widx_inc;
                        // Address parks on the last register while the
                        // trailing words go out.
                        if (widx_inc < NREGS_IDX) begin
                            addr_d = NB_ADDR'(widx_inc);
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            widx_q  <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
`ifdef DEBUG_PC_DUMP_EN
            pc_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            widx_q  <= widx_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            data_q  <= data_d;
`ifdef DEBUG_PC_DUMP_EN
            pc_q    <= pc_d;
`endif
        end
    end

    assign o_dump_addr = addr_q;
    assign o_tx_valid  = valid_q;
    assign o_tx_data   = data_q;

endmodule

// File: rtl/pipeline_debug_ctrl.sv
// Run/step/dump controller for the 5-stage pipeline.
// Gates the pipeline enable, detects HALT reaching WB, counts enabled
// cycles, and hands register dumps to debug_dump_seq.
// Ports:
//   i_clk, i_rst   clock, async active-high reset
//   bus (master)   command handshake, halt detect, pipeline enable,
//                  regfile debug port, dump word stream, status outputs
// Build option DEBUG_PC_DUMP_EN: the dump also carries the PC sampled
// at dump entry (bus.i_pc), ahead of the cycle count.
//
// state      | meaning
// -----------+--------------------------------------------------------
// ST_IDLE    | stopped, accepts RUN/STEP/DUMP
// ST_RUN     | pipeline enabled until HALT reaches WB
// ST_STEP    | pipeline enabled for this single cycle
// ST_DUMP_RD | dump in progress; debug_dump_seq alternates RD/TX itself
// ST_HALTED  | program finished; only DUMP is acted on
module pipeline_debug_ctrl #(
    parameter int LEN     = 32,
    parameter int NB_ADDR = 5,
    parameter int NB_REGS = 32,
    parameter int NB_CMD  = debug_pkg::NB_CMD
)(
    input  logic                 i_clk,
    input  logic                 i_rst,
    pipeline_debug_ctrl_if.master bus
);
    import debug_pkg::*;

    state_t          state_q, state_d;
    state_t          ret_q, ret_d;
    logic            pipe_en_q, cmd_ready_q, halted_q;
    logic [LEN-1:0]  cycle_cnt_q;
    logic            accept, dump_start, dump_done;
    logic [NB_CMD-1:0] cmd_raw;
    cmd_t            cmd;

    assign cmd_raw = bus.i_cmd;
    assign cmd     = cmd_t'(cmd_raw[1:0]);
    assign accept  = bus.i_cmd_valid && cmd_ready_q;

    always_comb begin
        state_d    = state_q;
        ret_d      = ret_q;
        dump_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (cmd)
                        CMD_RUN:  state_d = ST_RUN;
                        CMD_STEP: state_d = ST_STEP;
                        CMD_DUMP: begin
                            state_d    = ST_DUMP_RD;
                            ret_d      = ST_IDLE;
                            dump_start = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                if (bus.i_halt_wb) begin
                    state_d = ST_HALTED;
                end
            end
            ST_STEP: begin
                state_d = bus.i_halt_wb ? ST_HALTED : ST_IDLE;
            end
            ST_HALTED: begin
                // RUN/STEP are accepted and dropped here.
                if (accept && (cmd == CMD_DUMP)) begin
                    state_d    = ST_DUMP_RD;
                    ret_d      = ST_HALTED;
                    dump_start = 1'b1;
                end
            end
            ST_DUMP_RD, ST_DUMP_TX: begin
                if (dump_done) begin
                    state_d = ret_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            ret_q       <= ST_IDLE;
            pipe_en_q   <= 1'b0;
            cmd_ready_q <= 1'b1;
            halted_q    <= 1'b0;
            cycle_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            pipe_en_q   <= (state_d == ST_RUN) || (state_d == ST_STEP);
            cmd_ready_q <= (state_d == ST_IDLE) || (state_d == ST_HALTED);
            halted_q    <= halted_q || (state_d == ST_HALTED);
            if (pipe_en_q) begin
                cycle_cnt_q <= cycle_cnt_q + 1'b1;
            end
        end
    end

    debug_dump_seq #(
        .LEN     (LEN),
        .NB_ADDR (NB_ADDR),
        .NB_REGS (NB_REGS)
    ) u_dump_seq (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_start       (dump_start),
        .i_cycle_count (cycle_cnt_q),
`ifdef DEBUG_PC_DUMP_EN
        .i_pc          (bus.i_pc),
`endif
        .o_dump_addr   (bus.o_dump_addr),
        .i_dump_data   (bus.i_dump_data),
        .o_tx_valid    (bus.o_tx_valid),
        .o_tx_data     (bus.o_tx_data),
        .i_tx_ready    (bus.i_tx_ready),
        .o_done        (dump_done)
    );

    assign bus.o_pipe_en     = pipe_en_q;
    assign bus.o_cmd_ready   = cmd_ready_q;
    assign bus.o_halted      = halted_q;
    assign bus.o_cycle_count = cycle_cnt_q;

endmodule

// File: tb/tb_pipeline_debug_ctrl.sv
// Bench for pipeline_debug_ctrl: table of per-cycle command/halt vectors
// with expected status, then hand-written dump sequences (ready held high,
// ready throttled, reset mid-dump, dump from IDLE).
module tb_pipeline_debug_ctrl;
    import debug_pkg::*;

    localparam int LEN     = 32;
    localparam int NB_ADDR = 5;
    localparam int NB_REGS = 32;
`ifdef DEBUG_PC_DUMP_EN
    localparam int NB_WORDS = NB_REGS + 2;
    localparam logic [31:0] PC_VAL = 32'hF0001234;
`else
    localparam int NB_WORDS = NB_REGS + 1;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipeline_debug_ctrl_if #(.LEN(LEN), .NB_ADDR(NB_ADDR), .NB_CMD(2)) bus ();

    pipeline_debug_ctrl #(
        .LEN(LEN), .NB_ADDR(NB_ADDR), .NB_REGS(NB_REGS), .NB_CMD(2)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    // Register file model: reg[n] = 4*n, read combinationally from the address.
    assign bus.i_dump_data = {{(LEN-NB_ADDR-2){1'b0}}, bus.o_dump_addr, 2'b00};
`ifdef DEBUG_PC_DUMP_EN
    assign bus.i_pc = PC_VAL;
`endif

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        valid;
        logic [1:0]  cmd;
        logic        halt;
        logic        pe;
        logic        rdy;
        logic        hlt;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic v, input logic [1:0] c, input logic h,
                                input logic pe, input logic rdy, input logic hlt, input logic [31:0] cnt);
        vec_t x;
        x.rst = r; x.valid = v; x.cmd = c; x.halt = h;
        x.pe = pe; x.rdy = rdy; x.hlt = hlt; x.cnt = cnt;
        vecs.push_back(x);
    endfunction

    function automatic logic [31:0] exp_word(input int k, input logic [31:0] cnt);
        if (k < NB_REGS) return 32'(k * 4);
`ifdef DEBUG_PC_DUMP_EN
        if (k == NB_REGS) return PC_VAL;
`endif
        return cnt;
    endfunction

    // Issues DUMP at the current negedge and follows the word stream.
    // stop_after >= 0 returns as soon as that many words were taken.
    task automatic do_dump(input bit stall, input int stop_after,
                           input logic [31:0] exp_cnt, input bit exp_halted);
        int nw = 0, cyc = 0, hold_bad = 0, addr_bad = 0, pe_seen = 0;
        int rdy_early = 0, extra = 0;
        bit pend = 0;
        bit r;
        logic [31:0] pend_data = '0;
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd       = CMD_DUMP;
        while (cyc < 3000) begin
            @(negedge clk);
            cyc++;
            bus.i_cmd_valid = 1'b0;
            bus.i_cmd       = CMD_NOP;
            if (bus.o_pipe_en) pe_seen++;
            if (pend && (!bus.o_tx_valid || bus.o_tx_data !== pend_data)) hold_bad++;
            if (nw == NB_WORDS && bus.o_cmd_ready) break;
            if (bus.o_cmd_ready) rdy_early++;
            r = stall ? ($urandom_range(0, 2) == 0) : 1'b1;
            bus.i_tx_ready = r;
            pend = 0;
            if (bus.o_tx_valid) begin
                if (nw >= NB_WORDS) begin
                    if (r) extra++;
                end else begin
                    if (nw < NB_REGS && bus.o_dump_addr !== NB_ADDR'(nw)) addr_bad++;
                    if (r) begin
                        check($sformatf("dump_word%0d", nw), bus.o_tx_data, exp_word(nw, exp_cnt));
                        nw++;
                        if (stop_after >= 0 && nw == stop_after) return;
                    end else begin
                        pend      = 1;
                        pend_data = bus.o_tx_data;
                    end
                end
            end
        end
        check("dump_word_count", nw, NB_WORDS);
        check("dump_extra_words", extra, 0);
        check("dump_hold_violations", hold_bad, 0);
        check("dump_addr_errors", addr_bad, 0);
        check("dump_pipe_en_cycles", pe_seen, 0);
        check("dump_ready_during_dump", rdy_early, 0);
        check("dump_return_ready", bus.o_cmd_ready, 1);
        check("dump_return_valid", bus.o_tx_valid, 0);
        check("dump_return_addr", bus.o_dump_addr, 0);
        check("dump_return_halted", bus.o_halted, exp_halted);
        check("dump_return_cnt", bus.o_cycle_count, exp_cnt);
        if (!stall) check("dump_latency", cyc, 2 * NB_WORDS + 1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_pipe_en"}, bus.o_pipe_en, 0);
        check({tag, "_cmd_ready"}, bus.o_cmd_ready, 1);
        check({tag, "_halted"}, bus.o_halted, 0);
        check({tag, "_cycle_count"}, bus.o_cycle_count, 0);
        check({tag, "_tx_valid"}, bus.o_tx_valid, 0);
        check({tag, "_tx_data"}, bus.o_tx_data, 0);
        check({tag, "_dump_addr"}, bus.o_dump_addr, 0);
    endtask

    initial begin
        rst             = 1'b1;
        bus.i_cmd_valid = 1'b0;
        bus.i_cmd       = CMD_NOP;
        bus.i_halt_wb   = 1'b0;
        bus.i_tx_ready  = 1'b0;

        // STEP x3 from IDLE, then a NOP that must be ignored.
        add(0,1,CMD_STEP,0, 1,0,0,0);
        add(0,0,CMD_NOP ,0, 0,1,0,1);
        add(0,1,CMD_STEP,0, 1,0,0,1);
        add(0,0,CMD_NOP ,0, 0,1,0,2);
        add(0,1,CMD_STEP,0, 1,0,0,2);
        add(0,0,CMD_NOP ,0, 0,1,0,3);
        add(0,1,CMD_NOP ,0, 0,1,0,3);
        add(0,0,CMD_NOP ,0, 0,1,0,3);
        // STEP that retires HALT goes straight to HALTED.
        add(1,0,CMD_NOP ,0, 0,1,0,0);
        add(0,1,CMD_STEP,0, 1,0,0,0);
        add(0,0,CMD_NOP ,1, 0,1,1,1);
        add(0,1,CMD_STEP,0, 0,1,1,1);
        add(0,0,CMD_NOP ,0, 0,1,1,1);
        // RUN with HALT in its 10th enabled cycle; commands while running ignored.
        add(1,0,CMD_NOP ,0, 0,1,0,0);
        add(0,1,CMD_RUN ,0, 1,0,0,0);
        for (int k = 1; k <= 9; k++)
            add(0, (k == 5), (k == 5) ? CMD_STEP : CMD_NOP, 0, 1,0,0, 32'(k));
        add(0,0,CMD_NOP ,1, 0,1,1,10);
        add(0,0,CMD_NOP ,0, 0,1,1,10);
        add(0,1,CMD_STEP,0, 0,1,1,10);
        add(0,0,CMD_NOP ,0, 0,1,1,10);
        add(0,1,CMD_RUN ,0, 0,1,1,10);
        add(0,0,CMD_NOP ,0, 0,1,1,10);

        repeat (2) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            rst             = vecs[i].rst;
            bus.i_cmd_valid = vecs[i].valid;
            bus.i_cmd       = vecs[i].cmd;
            bus.i_halt_wb   = vecs[i].halt;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("v%0d_pipe_en", i), bus.o_pipe_en, vecs[i].pe);
            check($sformatf("v%0d_cmd_ready", i), bus.o_cmd_ready, vecs[i].rdy);
            check($sformatf("v%0d_halted", i), bus.o_halted, vecs[i].hlt);
            check($sformatf("v%0d_cycle_count", i), bus.o_cycle_count, vecs[i].cnt);
        end
        rst             = 1'b0;
        bus.i_cmd_valid = 1'b0;
        bus.i_halt_wb   = 1'b0;

        // From HALTED: ready held high, then throttled ready.
        do_dump(1'b0, -1, 32'd10, 1'b1);
        do_dump(1'b1, -1, 32'd10, 1'b1);

        // Reset in the middle of a dump.
        do_dump(1'b0, 7, 32'd10, 1'b1);
        rst = 1'b1;
        #1;
        check_reset_state("mid_dump_reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Fresh dump from IDLE restarts at register 0 and returns to IDLE.
        do_dump(1'b0, -1, 32'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
